// File: rtl/control_div_restoring.sv
// Control sequencer for a restoring divider datapath: issues one
// SH/SUB/(ADD|Q1) round per quotient bit, flags divide-by-zero and
// stretches DONE for DONE_HOLD cycles. All outputs come straight from
// flops so they are glitch-free Moore decodes of the state.
module control_div_restoring #(
    parameter int WIDTH     = 8,
    parameter int DONE_HOLD = 31
) (
    input  logic clk,
    input  logic rst_n,
    input  logic INIT,
    input  logic DZ,
    input  logic MSB,
    output logic LD,
    output logic SH,
    output logic SUB,
    output logic ADD,
    output logic Q1,
    output logic BUSY,
    output logic ERR,
    output logic DONE
);
    localparam int         CW        = $clog2(WIDTH + 1);
    localparam logic [5:0] HOLD_LAST = 6'(DONE_HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_CHECK   = 4'd2,
        S_SHIFT   = 4'd3,
        S_SUBTR   = 4'd4,
        S_TEST    = 4'd5,
        S_RESTORE = 4'd6,
        S_SETQ    = 4'd7,
        S_END     = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    hold_q, hold_d;
    logic          init_q;
    logic          ld_q, sh_q, sub_q, add_q, q1_q, busy_q, err_q, done_q;

    // Next-state and counter update; DZ only matters in CHECK, MSB only in TEST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE:    if (INIT && !init_q) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_CHECK;
                cnt_d   = CW'(WIDTH);
            end
            S_CHECK: begin
                hold_d  = '0;
                state_d = DZ ? S_ERROR : S_SHIFT;
            end
            S_SHIFT:   state_d = S_SUBTR;
            S_SUBTR:   state_d = S_TEST;
            S_TEST:    state_d = MSB ? S_RESTORE : S_SETQ;
            S_RESTORE, S_SETQ: begin
                // Saturating decrement: the counter never wraps below zero.
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = S_END;
                    hold_d  = '0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_END, S_ERROR: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q + 6'd1;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // State, counters, INIT edge history and output flops decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            init_q  <= 1'b0;
            ld_q    <= 1'b0;
            sh_q    <= 1'b0;
            sub_q   <= 1'b0;
            add_q   <= 1'b0;
            q1_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            init_q  <= INIT;
            ld_q    <= (state_d == S_LOAD);
            sh_q    <= (state_d == S_SHIFT);
            sub_q   <= (state_d == S_SUBTR);
            add_q   <= (state_d == S_RESTORE);
            q1_q    <= (state_d == S_SETQ);
            busy_q  <= (state_d != S_IDLE);
            err_q   <= (state_d == S_ERROR);
            done_q  <= (state_d == S_END) || (state_d == S_ERROR);
        end
    end

    assign LD   = ld_q;
    assign SH   = sh_q;
    assign SUB  = sub_q;
    assign ADD  = add_q;
    assign Q1   = q1_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;
    assign DONE = done_q;

endmodule

// File: doc/control_div_restoring.md
CONTROL_DIV_RESTORING -- requirements
Module: control_div_restoring

Interface
REQ-001 Parameter WIDTH, default 8: quotient bit count, one iteration per bit, legal range 2..32.
REQ-002 Parameter DONE_HOLD, default 31: number of cycles DONE stays high, legal range 1..63.
REQ-003 clk  input  1  processor clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 INIT  input  1  start request from the processor; the rising edge is detected internally.
REQ-006 DZ  input  1  datapath flag: divisor equals zero, valid from the cycle after LD.
REQ-007 MSB  input  1  datapath sign bit of the partial remainder A, valid in TEST.
REQ-008 LD  output  1  load dividend into Q, divisor into B, clear A.
REQ-009 SH  output  1  shift the {A,Q} pair left by 1.
REQ-010 SUB  output  1  load A-B into A.
REQ-011 ADD  output  1  restore: load A+B into A; Q0 is left at 0.
REQ-012 Q1  output  1  write Q0=1.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 ERR  output  1  divide-by-zero indication.
REQ-015 DONE  output  1  operation-finished pulse, stretched.

Function
REQ-016 All outputs SHALL be Moore outputs decoded from the state register only; at most one of LD/SH/SUB/ADD/Q1 is high in any cycle.
REQ-017 Start: the FSM SHALL leave IDLE only on a clock edge where INIT=1 and registered INIT (init_q) =0; a held-high INIT SHALL NOT retrigger.
REQ-018 States and transitions:
- IDLE -> LOAD on INIT rising edge.
- LOAD (LD=1) -> CHECK; iteration counter <= WIDTH.
- CHECK -> ERROR if DZ=1, else -> SHIFT.
- SHIFT (SH=1) -> SUBTR.
- SUBTR (SUB=1) -> TEST.
- TEST -> RESTORE if MSB=1, else -> SETQ.
- RESTORE (ADD=1) / SETQ (Q1=1): counter decrements; -> END if the counter was 1, else -> SHIFT.
- END (DONE=1) -> IDLE after DONE_HOLD cycles.
- ERROR (DONE=1, ERR=1) -> IDLE after DONE_HOLD cycles.
- Illegal encoding -> IDLE.
REQ-019 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap below 0.
REQ-020 The hold counter SHALL be 6 bits wide, cleared on entry to END/ERROR, and SHALL exit when it reaches DONE_HOLD-1.
REQ-021 Latency: END SHALL be entered exactly 2+4*WIDTH cycles after LOAD entry (34 for WIDTH=8); ERROR SHALL be entered 2 cycles after LOAD entry.
REQ-022 INIT edges while BUSY=1 SHALL be ignored, and init_q SHALL keep tracking INIT so that no edge is queued.
REQ-023 DZ SHALL be sampled only in CHECK; MSB SHALL be sampled only in TEST; changes to either elsewhere SHALL have no effect.
REQ-024 The cycle after leaving END/ERROR SHALL be IDLE with DONE=0, even if INIT is high.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force state=IDLE, both counters=0, init_q=0, and all outputs=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abort without any further datapath strobe; after release, a new INIT rising edge is required to start.
REQ-027 If INIT is already high when rst_n releases, that SHALL count as a rising edge on the first clock, because init_q=0.

Verification
REQ-028 WIDTH=8, INIT 0->1, DZ=0, MSB pattern 1,0,1,0,... -> LD at cycle 0, 8 SH/SUB pairs, ADD/Q1 alternating starting with ADD, DONE high for exactly 31 cycles starting at cycle 34.
REQ-029 DZ=1 in CHECK -> no SH/SUB/ADD/Q1, ERR=DONE=1 for 31 cycles starting at cycle 2, then IDLE.
REQ-030 INIT held high for 200 cycles -> exactly one operation; BUSY=0 after DONE falls, with no restart.
REQ-031 Second INIT pulse during SUBTR of iteration 3 -> ignored; the strobe sequence and total latency are unchanged.
REQ-032 rst_n pulsed low during iteration 5 -> all outputs 0 immediately with no clock; after release, IDLE is held until a new INIT edge.
REQ-033 DONE_HOLD=1, WIDTH=2 -> END entered at cycle 10, DONE high for exactly 1 cycle, and the next INIT edge is accepted the following cycle.
